// File: rtl/snd_i2s_out.sv
// snd_i2s_out: mono mixer plus 48 kHz stereo I2S serialiser for the audio DAC.
// The whole block runs on the 12.288 MHz audio clock, which is also the DAC MCLK.
// An 8-bit free-running frame counter produces the timing. Bit clock = clk/4 and
// word select = clk/256. One mixed sample is held and then sent on both the left
// and right channels of the next frame.
module snd_i2s_out #(
  parameter bit ATTEN = 1'b0  // 0: saturating sum, 1: sum >>> 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] snd1,
  input  logic [15:0] snd2,
  output logic        sclk,
  output logic        lrck,
  output logic        dac,
  output logic        overrun
);

  // Frame timing and sample storage
  logic [7:0]  cnt_q,     cnt_d;
  logic [15:0] hold_q,    hold_d;
  logic [15:0] frame_q,   frame_d;
  logic        fresh_q,   fresh_d;

  // Registered pin drivers
  logic        sclk_q,    sclk_d;
  logic        lrck_q,    lrck_d;
  logic        dac_q,     dac_d;
  logic        overrun_q, overrun_d;

  // Combinational helpers
  logic [16:0] sum_s;
  logic [15:0] mix_s;
  logic        wrap_s;
  logic [4:0]  bidx_s;
  logic [4:0]  sel_w_s;
  logic [3:0]  sel_s;

  // Mix both channels to mono: 17-bit signed sum, then clamp or halve
  always_comb begin
    sum_s = {snd1[15], snd1} + {snd2[15], snd2};
    mix_s = sum_s[15:0];
    if (ATTEN) begin
      // Arithmetic shift of the 17-bit sum always fits in 16 bits
      mix_s = sum_s[16:1];
    end else if (sum_s[16] != sum_s[15]) begin
      // Sign bits disagree: the sum left the 16-bit range, pick the rail
      mix_s = sum_s[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      mix_s = sum_s[15:0];
    end
  end

  // Frame counter advance and hold/frame/fresh bookkeeping
  always_comb begin
    cnt_d     = cnt_q + 8'd1;
    wrap_s    = (cnt_q == 8'd255);
    hold_d    = hold_q;
    frame_d   = frame_q;
    fresh_d   = fresh_q;
    overrun_d = 1'b0;

    // The frame takes whatever is held at the wrap, so missing input simply repeats.
    if (wrap_s) begin
      frame_d = hold_q;
      fresh_d = 1'b0;
    end else begin
      frame_d = frame_q;
    end

    // A new sample always wins the hold register. Dropping an unconsumed one is
    // reported only when the wrap is not taking it in the same cycle.
    if (in_valid) begin
      hold_d    = mix_s;
      fresh_d   = 1'b1;
      overrun_d = fresh_q & ~wrap_s;
    end else begin
      hold_d    = hold_q;
    end
  end

  // Serial pin values for the current counter state, registered one clk later
  always_comb begin
    bidx_s  = cnt_q[6:2];
    sel_w_s = 5'd16 - bidx_s;
    sel_s   = sel_w_s[3:0];
    sclk_d  = cnt_q[1];
    lrck_d  = cnt_q[7];
    // Slot 0 is the I2S one-bit delay. Slots 1..16 carry MSB..LSB and the rest are zero.
    if ((bidx_s >= 5'd1) && (bidx_s <= 5'd16)) begin
      dac_d = frame_q[sel_s];
    end else begin
      dac_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset; reset restarts the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 8'd0;
      hold_q    <= 16'h0000;
      frame_q   <= 16'h0000;
      fresh_q   <= 1'b0;
      sclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      dac_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      frame_q   <= frame_d;
      fresh_q   <= fresh_d;
      sclk_q    <= sclk_d;
      lrck_q    <= lrck_d;
      dac_q     <= dac_d;
      overrun_q <= overrun_d;
    end
  end

  assign sclk    = sclk_q;
  assign lrck    = lrck_q;
  assign dac     = dac_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_snd_i2s_out.sv
// Directed bench for snd_i2s_out. Two instances receive the same stimulus:
// one saturating (ATTEN=0) and one attenuating (ATTEN=1). Each accepted sample
// pushes the expected value for both modes to a scoreboard, tagged with the
// frame it must appear in. Each frame pops its expected value and checks
// every serial clock of both instances against it.
module tb_snd_i2s_out;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] snd1;
  logic [15:0] snd2;
  logic        sclk_s, lrck_s, dac_s, ovr_s;
  logic        sclk_a, lrck_a, dac_a, ovr_a;

  snd_i2s_out #(.ATTEN(1'b0)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .snd1(snd1), .snd2(snd2),
    .sclk(sclk_s), .lrck(lrck_s), .dac(dac_s), .overrun(ovr_s)
  );

  snd_i2s_out #(.ATTEN(1'b1)) u_att (
    .clk(clk), .reset(reset), .in_valid(in_valid), .snd1(snd1), .snd2(snd2),
    .sclk(sclk_a), .lrck(lrck_a), .dac(dac_a), .overrun(ovr_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    logic [15:0] v_sat;
    logic [15:0] v_att;
  } sb_t;

  sb_t         q[$];
  logic [15:0] last_sat;
  logic [15:0] last_att;
  int          frame_no;
  int          n_assert;
  int          n_fail;

  function automatic logic [15:0] mix_ref(input logic [15:0] a, input logic [15:0] b, input bit att);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (att) s = s >>> 1;
    else if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for four clocks. All pins of both instances must read 0.
  task automatic do_reset(input string tag);
    int bad;
    bad = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    snd1     = 16'h0000;
    snd2     = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      step();
      if ({sclk_s, lrck_s, dac_s, ovr_s, sclk_a, lrck_a, dac_a, ovr_a} !== 8'h00) bad++;
    end
    chk({tag, "_pins_zero"}, bad, 0);
    reset = 1'b0;
    q.delete();
    last_sat = 16'h0000;
    last_att = 16'h0000;
  endtask

  // Run one frame from cnt=0. Inject up to two samples at counter positions
  // at1/at2 (-1 = none). Optionally stop early at rst_at for a reset.
  task automatic run_frame(input string tag,
                           input int at1, input logic [15:0] a1, input logic [15:0] b1,
                           input int at2, input logic [15:0] a2, input logic [15:0] b2,
                           input int rst_at);
    logic [15:0] exp_s, exp_a;
    logic [15:0] wl_s, wr_s, wl_a, wr_a;
    int tm_err, dac_err_s, dac_err_a, ovr_err, bidx, tgt;
    bit hit1, hit2, exp_ovr, aborted;
    logic e_sclk, e_lrck, e_dac_s, e_dac_a;
    sb_t e;

    while (q.size() > 0 && q[0].frame <= frame_no) begin
      e = q.pop_front();
      last_sat = e.v_sat;
      last_att = e.v_att;
    end
    exp_s = last_sat;
    exp_a = last_att;
    wl_s = 16'h0000; wr_s = 16'h0000; wl_a = 16'h0000; wr_a = 16'h0000;
    tm_err = 0; dac_err_s = 0; dac_err_a = 0; ovr_err = 0; aborted = 1'b0;

    for (int i = 0; i < 256; i++) begin
      if (i == rst_at) begin
        aborted = 1'b1;
        break;
      end
      hit1 = (i == at1);
      hit2 = (i == at2);
      in_valid = hit1 || hit2;
      snd1 = hit1 ? a1 : (hit2 ? a2 : 16'h0000);
      snd2 = hit1 ? b1 : (hit2 ? b2 : 16'h0000);
      exp_ovr = 1'b0;
      if (in_valid) begin
        tgt = (i == 255) ? frame_no + 2 : frame_no + 1;
        exp_ovr = (q.size() > 0) && (q[$].frame == tgt);
        e.frame = tgt;
        e.v_sat = mix_ref(snd1, snd2, 1'b0);
        e.v_att = mix_ref(snd1, snd2, 1'b1);
        q.push_back(e);
      end
      step();
      // The pins now show counter state i
      bidx    = (i >> 2) & 31;
      e_sclk  = ((i >> 1) & 1) != 0;
      e_lrck  = ((i >> 7) & 1) != 0;
      e_dac_s = (bidx >= 1 && bidx <= 16) ? exp_s[16 - bidx] : 1'b0;
      e_dac_a = (bidx >= 1 && bidx <= 16) ? exp_a[16 - bidx] : 1'b0;
      if (sclk_s !== e_sclk || lrck_s !== e_lrck) tm_err++;
      if (sclk_a !== e_sclk || lrck_a !== e_lrck) tm_err++;
      if (dac_s !== e_dac_s) dac_err_s++;
      if (dac_a !== e_dac_a) dac_err_a++;
      if (ovr_s !== exp_ovr || ovr_a !== exp_ovr) ovr_err++;
      // Receiver view: sample data at the middle of each bit slot
      if ((i & 3) == 2 && bidx >= 1 && bidx <= 16) begin
        if (e_lrck) begin
          wr_s[16 - bidx] = dac_s;
          wr_a[16 - bidx] = dac_a;
        end else begin
          wl_s[16 - bidx] = dac_s;
          wl_a[16 - bidx] = dac_a;
        end
      end
    end
    in_valid = 1'b0;
    snd1 = 16'h0000;
    snd2 = 16'h0000;

    chk({tag, "_sclk_lrck"}, tm_err, 0);
    chk({tag, "_overrun"}, ovr_err, 0);
    chk({tag, "_dac_bits_sat"}, dac_err_s, 0);
    chk({tag, "_dac_bits_att"}, dac_err_a, 0);
    if (!aborted) begin
      chk({tag, "_left_sat"},  wl_s, exp_s);
      chk({tag, "_right_sat"}, wr_s, exp_s);
      chk({tag, "_left_att"},  wl_a, exp_a);
      chk({tag, "_right_att"}, wr_a, exp_a);
    end
    frame_no++;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    snd1     = 16'h0000;
    snd2     = 16'h0000;
    frame_no = 0;
    n_assert = 0;
    n_fail   = 0;
    last_sat = 16'h0000;
    last_att = 16'h0000;

    do_reset("power_up");
    // First frame is silent. Queue the positive-saturation case for the next frame.
    run_frame("f0_zero",        20, 16'h4000, 16'h4000, -1, 16'h0000, 16'h0000, -1);
    run_frame("f1_sat_pos",     50, 16'h8000, 16'hFFFF, -1, 16'h0000, 16'h0000, -1);
    run_frame("f2_sat_neg",     30, 16'hFFFF, 16'h0000, -1, 16'h0000, 16'h0000, -1);
    run_frame("f3_minus_one",   60, 16'hA5C3, 16'h0000, -1, 16'h0000, 16'h0000, -1);
    // Bit alignment of 0xA5C3. Two samples 10 clocks apart: one overrun, second wins.
    run_frame("f4_align",       40, 16'h1234, 16'h0000, 50, 16'h0100, 16'h0010, -1);
    run_frame("f5_second_wins", -1, 16'h0000, 16'h0000, -1, 16'h0000, 16'h0000, -1);
    // Starvation: the last value repeats silently.
    run_frame("f6_repeat1",     -1, 16'h0000, 16'h0000, -1, 16'h0000, 16'h0000, -1);
    run_frame("f7_repeat2",     -1, 16'h0000, 16'h0000, -1, 16'h0000, 16'h0000, -1);
    // Still repeating. A fresh sample at 100 plus another on the wrap cycle: no overrun.
    run_frame("f8_repeat3",    100, 16'h0300, 16'h0003, 255, 16'h2000, 16'h1000, -1);
    run_frame("f9_wrap_old",    -1, 16'h0000, 16'h0000, 255, 16'h0005, 16'h0002, -1);
    run_frame("f10_wrap_new",   -1, 16'h0000, 16'h0000, -1, 16'h0000, 16'h0000, -1);
    run_frame("f11_wrap_only",  -1, 16'h0000, 16'h0000, -1, 16'h0000, 16'h0000, -1);
    // A pending sample, then reset at cnt=100.
    run_frame("f12_pre_reset",  30, 16'h7000, 16'h0001, -1, 16'h0000, 16'h0000, 100);
    do_reset("mid_frame");
    run_frame("f13_post_reset", 60, 16'h0042, 16'h0000, -1, 16'h0000, 16'h0000, -1);
    run_frame("f14_resume",     -1, 16'h0000, 16'h0000, -1, 16'h0000, 16'h0000, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
